// File: rtl/flush_redirect_unit_pkg.sv
// Shared types and constants for the flush/redirect consumer: FSM states,
// flush-cause encodings ordered by priority, and the boot fetch address.
package flush_redirect_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_IDLE,
        ST_INV,
        ST_PEND
    } state_e;

    // Listed from highest to lowest priority; CAUSE_NONE means no flush this cycle.
    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_IRQ,
        CAUSE_ECALL,
        CAUSE_MRET,
        CAUSE_FENCEI,
        CAUSE_CSR,
        CAUSE_BRANCH
    } cause_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Causes raised by the instruction in WB, which is older than anything in EX2.
    function automatic logic is_wb_cause(input cause_e c);
        return (c == CAUSE_IRQ) || (c == CAUSE_ECALL) ||
               (c == CAUSE_MRET) || (c == CAUSE_CSR);
    endfunction

endpackage

// File: rtl/flush_redirect_unit_redirect_target_sel.sv
// Combinational priority mux: picks the winning flush cause and its
// word-aligned redirect target.
module redirect_target_sel
    import flush_redirect_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            interrupt_taken,
    input  logic            is_ecall_instr_in_wb,
    input  logic            is_mret_instr_in_wb,
    input  logic            is_csr_instr_in_wb,
    input  logic            is_fencei_wb,
    input  logic            branch_taken_ex2,
    input  logic [XLEN-1:0] pc_wb,
    input  logic [XLEN-1:0] branch_target_ex2,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output cause_e          cause,
    output logic [XLEN-1:0] target_pc,
    output logic            is_fencei
);

    logic [XLEN-1:0] raw_pc;

    always_comb begin
        cause  = CAUSE_NONE;
        raw_pc = branch_target_ex2;
        if (interrupt_taken) begin
            cause  = CAUSE_IRQ;
            raw_pc = mtvec;
        end else if (is_ecall_instr_in_wb) begin
            cause  = CAUSE_ECALL;
            raw_pc = mtvec;
        end else if (is_mret_instr_in_wb) begin
            cause  = CAUSE_MRET;
            raw_pc = mepc;
        end else if (is_fencei_wb) begin
            cause  = CAUSE_FENCEI;
            raw_pc = pc_wb + XLEN'(4);
        end else if (is_csr_instr_in_wb) begin
            cause  = CAUSE_CSR;
            raw_pc = pc_wb + XLEN'(4);
        end else if (branch_taken_ex2) begin
            cause  = CAUSE_BRANCH;
            raw_pc = branch_target_ex2;
        end
    end

    // Fetch is word-granular, so low bits of vector/target are dropped.
    assign target_pc = raw_pc & ~XLEN'(3);
    assign is_fencei = (cause == CAUSE_FENCEI);

endmodule

// File: rtl/flush_redirect_unit.sv
// Turns qualified flush causes into a single registered PC redirect to IF,
// sequencing the I-cache invalidate for fence.i and the boot redirect.
module flush_redirect_unit
    import flush_redirect_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             interrupt_taken,
    input  logic             is_ecall_instr_in_wb,
    input  logic             is_mret_instr_in_wb,
    input  logic             is_csr_instr_in_wb,
    input  logic             is_fencei_wb,
    input  logic             branch_taken_ex2,
    input  logic [XLEN-1:0]  pc_wb,
    input  logic [XLEN-1:0]  branch_target_ex2,
    input  logic [XLEN-1:0]  mtvec,
    input  logic [XLEN-1:0]  mepc,
    input  logic             icache_inv_ack,
    input  logic             if_ready,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             icache_inv_req,
    output logic             front_hold,
    output logic [CNT_W-1:0] redirect_cnt
);

    state_e           state_q, state_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             icache_inv_req_q, icache_inv_req_d;
    logic             front_hold_q, front_hold_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    cause_e          cause;
    logic [XLEN-1:0] target_pc;
    logic            is_fencei;
    logic            wb_cause;
    logic            accept;

    redirect_target_sel #(.XLEN(XLEN)) u_target_sel (
        .interrupt_taken      (interrupt_taken),
        .is_ecall_instr_in_wb (is_ecall_instr_in_wb),
        .is_mret_instr_in_wb  (is_mret_instr_in_wb),
        .is_csr_instr_in_wb   (is_csr_instr_in_wb),
        .is_fencei_wb         (is_fencei_wb),
        .branch_taken_ex2     (branch_taken_ex2),
        .pc_wb                (pc_wb),
        .branch_target_ex2    (branch_target_ex2),
        .mtvec                (mtvec),
        .mepc                 (mepc),
        .cause                (cause),
        .target_pc            (target_pc),
        .is_fencei            (is_fencei)
    );

    assign wb_cause = is_wb_cause(cause);
    assign accept   = redirect_valid_q && if_ready;

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        icache_inv_req_d = icache_inv_req_q;
        redirect_cnt_d   = redirect_cnt_q;
        unique case (state_q)
            ST_BOOT: begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = RESET_PC;
                state_d          = ST_PEND;
            end
            ST_IDLE: begin
                // fence.i parks its refetch PC in redirect_pc until the invalidate is done.
                if (is_fencei) begin
                    redirect_pc_d    = target_pc;
                    icache_inv_req_d = 1'b1;
                    state_d          = ST_INV;
                end else if (cause != CAUSE_NONE) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = target_pc;
                    state_d          = ST_PEND;
                end
            end
            ST_INV: begin
                if (icache_inv_ack) begin
                    icache_inv_req_d = 1'b0;
                    redirect_valid_d = 1'b1;
                    state_d          = ST_PEND;
                end
            end
            ST_PEND: begin
                if (is_fencei) begin
                    redirect_valid_d = 1'b0;
                    redirect_pc_d    = target_pc;
                    icache_inv_req_d = 1'b1;
                    state_d          = ST_INV;
                end else begin
                    if (accept) begin
                        redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
                    end
                    // A younger branch never displaces a pending redirect; WB causes do.
                    if (wb_cause) begin
                        redirect_pc_d = target_pc;
                    end else if (accept) begin
                        redirect_valid_d = 1'b0;
                        state_d          = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase
        front_hold_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_BOOT;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= RESET_PC;
            icache_inv_req_q <= 1'b0;
            front_hold_q     <= 1'b1;
            redirect_cnt_q   <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            icache_inv_req_q <= icache_inv_req_d;
            front_hold_q     <= front_hold_d;
            redirect_cnt_q   <= redirect_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign icache_inv_req = icache_inv_req_q;
    assign front_hold     = front_hold_q;
    assign redirect_cnt   = redirect_cnt_q;

endmodule

// File: tb/tb_flush_redirect_unit.sv
// Bench for flush_redirect_unit: directed scenarios plus random traffic
// checked against a transaction-level model of the redirect rules.
module tb_flush_redirect_unit;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        interrupt_taken, is_ecall_instr_in_wb, is_mret_instr_in_wb;
    logic        is_csr_instr_in_wb, is_fencei_wb, branch_taken_ex2;
    logic [31:0] pc_wb, branch_target_ex2, mtvec, mepc;
    logic        icache_inv_ack, if_ready;
    logic        redirect_valid, icache_inv_req, front_hold;
    logic [31:0] redirect_pc, redirect_cnt;

    int checks = 0;
    int failures = 0;

    // Model: is a boot redirect due, is a redirect offered to IF, is an invalidate outstanding.
    bit          m_boot, m_valid, m_inv;
    logic [31:0] m_pc, m_cnt;

    flush_redirect_unit #(.XLEN(32), .RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .interrupt_taken(interrupt_taken),
        .is_ecall_instr_in_wb(is_ecall_instr_in_wb),
        .is_mret_instr_in_wb(is_mret_instr_in_wb),
        .is_csr_instr_in_wb(is_csr_instr_in_wb),
        .is_fencei_wb(is_fencei_wb),
        .branch_taken_ex2(branch_taken_ex2),
        .pc_wb(pc_wb), .branch_target_ex2(branch_target_ex2),
        .mtvec(mtvec), .mepc(mepc),
        .icache_inv_ack(icache_inv_ack), .if_ready(if_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .icache_inv_req(icache_inv_req), .front_hold(front_hold),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        interrupt_taken = 0; is_ecall_instr_in_wb = 0; is_mret_instr_in_wb = 0;
        is_csr_instr_in_wb = 0; is_fencei_wb = 0; branch_taken_ex2 = 0;
        icache_inv_ack = 0;
    endtask

    task automatic model_reset();
        m_boot = 1; m_valid = 0; m_inv = 0; m_pc = RST_PC; m_cnt = 0;
    endtask

    // Applies one clock edge's worth of the redirect rules to the model.
    task automatic model_edge();
        int          kind;   // 0 none, 1 WB redirect, 2 fence.i, 3 branch
        logic [31:0] tgt;
        kind = 0; tgt = 0;
        if (interrupt_taken)           begin kind = 1; tgt = mtvec; end
        else if (is_ecall_instr_in_wb) begin kind = 1; tgt = mtvec; end
        else if (is_mret_instr_in_wb)  begin kind = 1; tgt = mepc; end
        else if (is_fencei_wb)         begin kind = 2; tgt = pc_wb + 32'd4; end
        else if (is_csr_instr_in_wb)   begin kind = 1; tgt = pc_wb + 32'd4; end
        else if (branch_taken_ex2)     begin kind = 3; tgt = branch_target_ex2; end
        tgt = {tgt[31:2], 2'b00};
        if (m_boot) begin
            m_boot = 0; m_valid = 1; m_pc = RST_PC;
        end else if (m_inv) begin
            if (icache_inv_ack) begin m_inv = 0; m_valid = 1; end
        end else if (m_valid) begin
            if (kind == 2) begin
                m_valid = 0; m_inv = 1; m_pc = tgt;
            end else begin
                if (if_ready) m_cnt = m_cnt + 1;
                if (kind == 1) m_pc = tgt;
                else if (if_ready) m_valid = 0;
            end
        end else begin
            if (kind == 2) begin m_inv = 1; m_pc = tgt; end
            else if (kind != 0) begin m_valid = 1; m_pc = tgt; end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        if_ready = 1; pc_wb = 0; branch_target_ex2 = 0; mtvec = 0; mepc = 0;
        #2 rst = 1;
        model_reset();
        #1;
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", redirect_valid); end
        checks++; if (redirect_pc !== RST_PC) begin failures++; $display("FAIL reset_pc got=%h want=%h", redirect_pc, RST_PC); end
        checks++; if (icache_inv_req !== 1'b0) begin failures++; $display("FAIL reset_inv got=%b want=0", icache_inv_req); end
        checks++; if (front_hold !== 1'b1) begin failures++; $display("FAIL reset_hold got=%b want=1", front_hold); end
        checks++; if (redirect_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", redirect_cnt); end
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_boot();
        if_ready = 1;
        step();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== RST_PC) begin failures++; $display("FAIL boot_redirect got=%b/%h want=1/%h", redirect_valid, redirect_pc, RST_PC); end
        checks++; if (front_hold !== 1'b1) begin failures++; $display("FAIL boot_hold got=%b want=1", front_hold); end
        step();
        checks++; if (redirect_valid !== 1'b0 || redirect_cnt !== 32'd1) begin failures++; $display("FAIL boot_accept got=%b/%0d want=0/1", redirect_valid, redirect_cnt); end
        checks++; if (front_hold !== 1'b0) begin failures++; $display("FAIL boot_idle_hold got=%b want=0", front_hold); end
    endtask

    task automatic test_branch_hold();
        logic [31:0] cnt0;
        cnt0 = m_cnt;
        clear_inputs();
        branch_taken_ex2 = 1; branch_target_ex2 = 32'h8000_0104; if_ready = 0;
        step();
        branch_taken_ex2 = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0104) begin failures++; $display("FAIL branch_held[%0d] got=%b/%h want=1/80000104", i, redirect_valid, redirect_pc); end
            if (i < 2) step();
        end
        if_ready = 1;
        step();
        checks++; if (redirect_valid !== 1'b0 || redirect_cnt !== cnt0 + 32'd1) begin failures++; $display("FAIL branch_accept got=%b/%0d want=0/%0d", redirect_valid, redirect_cnt, cnt0 + 1); end
    endtask

    task automatic test_irq_vs_branch();
        clear_inputs();
        interrupt_taken = 1; branch_taken_ex2 = 1;
        mtvec = 32'h8000_0041; branch_target_ex2 = 32'h8000_0104; if_ready = 0;
        step();
        clear_inputs();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0040) begin failures++; $display("FAIL irq_wins got=%b/%h want=1/80000040", redirect_valid, redirect_pc); end
        if_ready = 1;
        step();
        checks++; if (redirect_valid !== 1'b0 || front_hold !== 1'b0) begin failures++; $display("FAIL irq_accept got=%b/%b want=0/0", redirect_valid, front_hold); end
    endtask

    task automatic test_pend_override();
        logic [31:0] cnt0;
        cnt0 = m_cnt;
        clear_inputs();
        branch_taken_ex2 = 1; branch_target_ex2 = 32'h8000_0300; if_ready = 0;
        step();
        branch_taken_ex2 = 0;
        step();
        is_ecall_instr_in_wb = 1; mtvec = 32'h8000_0200;
        step();
        is_ecall_instr_in_wb = 0;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0200) begin failures++; $display("FAIL ecall_override got=%b/%h want=1/80000200", redirect_valid, redirect_pc); end
        if_ready = 1;
        step();
        checks++; if (redirect_valid !== 1'b0 || redirect_cnt !== cnt0 + 32'd1) begin failures++; $display("FAIL override_count got=%b/%0d want=0/%0d", redirect_valid, redirect_cnt, cnt0 + 1); end
    endtask

    task automatic test_fencei();
        clear_inputs();
        is_fencei_wb = 1; pc_wb = 32'h8000_0010; if_ready = 1;
        step();
        is_fencei_wb = 0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (icache_inv_req !== 1'b1 || redirect_valid !== 1'b0 || front_hold !== 1'b1) begin failures++; $display("FAIL fencei_inv[%0d] got=%b/%b/%b want=1/0/1", i, icache_inv_req, redirect_valid, front_hold); end
            if (i < 4) begin
                interrupt_taken = (i == 1); branch_taken_ex2 = (i == 2);
                step();
                interrupt_taken = 0; branch_taken_ex2 = 0;
            end
        end
        icache_inv_ack = 1; if_ready = 0;
        step();
        icache_inv_ack = 0;
        checks++; if (icache_inv_req !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0014) begin failures++; $display("FAIL fencei_redirect got=%b/%b/%h want=0/1/80000014", icache_inv_req, redirect_valid, redirect_pc); end
        if_ready = 1;
        step();
        checks++; if (redirect_valid !== 1'b0 || front_hold !== 1'b0) begin failures++; $display("FAIL fencei_accept got=%b/%b want=0/0", redirect_valid, front_hold); end
    endtask

    task automatic test_reset_in_inv();
        clear_inputs();
        is_fencei_wb = 1; pc_wb = 32'h8000_0800;
        step();
        is_fencei_wb = 0;
        #3 rst = 1;
        model_reset();
        #1;
        checks++; if (icache_inv_req !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL async_reset got=%b/%b want=0/0", icache_inv_req, redirect_valid); end
        checks++; if (redirect_cnt !== 32'd0 || front_hold !== 1'b1) begin failures++; $display("FAIL async_reset_cnt got=%0d/%b want=0/1", redirect_cnt, front_hold); end
        repeat (2) @(posedge clk);
        #1 rst = 0; if_ready = 1;
        step();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== RST_PC) begin failures++; $display("FAIL reboot got=%b/%h want=1/%h", redirect_valid, redirect_pc, RST_PC); end
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            interrupt_taken      = ($urandom_range(0, 11) == 0);
            is_ecall_instr_in_wb = ($urandom_range(0, 11) == 0);
            is_mret_instr_in_wb  = ($urandom_range(0, 11) == 0);
            is_csr_instr_in_wb   = ($urandom_range(0, 11) == 0);
            is_fencei_wb         = ($urandom_range(0, 15) == 0);
            branch_taken_ex2     = ($urandom_range(0, 5) == 0);
            icache_inv_ack       = ($urandom_range(0, 3) == 0);
            if_ready             = ($urandom_range(0, 1) == 1);
            pc_wb = $urandom; branch_target_ex2 = $urandom;
            mtvec = $urandom; mepc = $urandom;
            step();
            checks++; if (redirect_valid !== m_valid) begin failures++; $display("FAIL rnd_valid[%0d] got=%b want=%b", n, redirect_valid, m_valid); end
            checks++; if (icache_inv_req !== m_inv) begin failures++; $display("FAIL rnd_inv[%0d] got=%b want=%b", n, icache_inv_req, m_inv); end
            checks++; if (front_hold !== (m_boot | m_valid | m_inv)) begin failures++; $display("FAIL rnd_hold[%0d] got=%b want=%b", n, front_hold, m_boot | m_valid | m_inv); end
            checks++; if (redirect_cnt !== m_cnt) begin failures++; $display("FAIL rnd_cnt[%0d] got=%0d want=%0d", n, redirect_cnt, m_cnt); end
            if (m_valid) begin
                checks++; if (redirect_pc !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d] got=%h want=%h", n, redirect_pc, m_pc); end
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_boot();
        test_branch_hold();
        test_irq_vs_branch();
        test_pend_override();
        test_fencei();
        test_reset_in_inv();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
